// File: rtl/frame_builder.sv
// Serial frame builder for the optical line driver: sync preamble, payload,
// parity bit and inter-frame gap, shifted out MSB first at CLKS_PER_BIT clocks per bit.
module frame_builder #(
  parameter int unsigned       DATA_W       = 28,
  parameter int unsigned       SYNC_W       = 8,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = 8'hA5,
  parameter bit                PARITY_ODD   = 1'b0,
  parameter int unsigned       GAP_BITS     = 2,
  parameter int unsigned       CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              vin,
  output logic              ready,
  output logic              dout,
  output logic              dout_valid,
  output logic              frame_start,
  output logic              busy
);

  localparam int unsigned SH_W     = SYNC_W + DATA_W + 1;
  localparam int unsigned MAX_SD   = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
  localparam int unsigned MAX_BITS = (GAP_BITS > MAX_SD) ? GAP_BITS : MAX_SD;
  localparam int unsigned BIT_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
  localparam int unsigned DIV_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] SYNC_LAST = BIT_W'(SYNC_W - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] GAP_LAST  = BIT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PARITY,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [SH_W-1:0]   sh_q, sh_d;
  logic              accept;
  logic              bit_end;
  logic              ready_d, dout_d, dout_valid_d, frame_start_d, busy_d;

  // Preamble, payload and parity share one shift register; its MSB is the line bit.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    accept  = (state_q == IDLE) && vin && ready;
    bit_end = (div_q == DIV_LAST);

    if (state_q == IDLE) begin
      if (accept) begin
        state_d = SYNC;
        div_d   = '0;
        bit_d   = '0;
        sh_d    = {SYNC_PATTERN, din, (^din) ^ PARITY_ODD};
      end
    end else if (bit_end) begin
      div_d = '0;
      bit_d = bit_q + 1'b1;
      if (state_q != GAP) begin
        sh_d = {sh_q[SH_W-2:0], 1'b0};
      end
      case (state_q)
        SYNC: begin
          if (bit_q == SYNC_LAST) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (bit_q == DATA_LAST) begin
            state_d = PARITY;
            bit_d   = '0;
          end
        end
        PARITY: begin
          state_d = (GAP_BITS > 0) ? GAP : IDLE;
          bit_d   = '0;
        end
        GAP: begin
          if (bit_q == GAP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          bit_d   = '0;
        end
      endcase
    end else begin
      div_d = div_q + 1'b1;
    end

    // Outputs are registered from the next state so the line tracks the FSM without lag.
    ready_d       = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    dout_valid_d  = (state_d == SYNC) || (state_d == DATA) || (state_d == PARITY);
    dout_d        = dout_valid_d & sh_d[SH_W-1];
    frame_start_d = accept;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      sh_q        <= '0;
      ready       <= 1'b0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      sh_q        <= sh_d;
      ready       <= ready_d;
      dout        <= dout_d;
      dout_valid  <= dout_valid_d;
      frame_start <= frame_start_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_frame_builder.sv
// Directed bench for frame_builder: default, odd-parity and small/slow configurations.
module tb_frame_builder;

  logic clk;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   acc_t[$];

  logic        rst_a, vin_a, ready_a, dout_a, dout_valid_a, frame_start_a, busy_a;
  logic [27:0] din_a;
  logic        rst_b, vin_b, ready_b, dout_b, dout_valid_b, frame_start_b, busy_b;
  logic [27:0] din_b;
  logic        rst_c, vin_c, ready_c, dout_c, dout_valid_c, frame_start_c, busy_c;
  logic [7:0]  din_c;

  frame_builder u_dflt (
    .clk(clk), .rst(rst_a), .din(din_a), .vin(vin_a), .ready(ready_a), .dout(dout_a),
    .dout_valid(dout_valid_a), .frame_start(frame_start_a), .busy(busy_a)
  );

  frame_builder #(.PARITY_ODD(1'b1)) u_odd (
    .clk(clk), .rst(rst_b), .din(din_b), .vin(vin_b), .ready(ready_b), .dout(dout_b),
    .dout_valid(dout_valid_b), .frame_start(frame_start_b), .busy(busy_b)
  );

  frame_builder #(
    .DATA_W(8), .SYNC_W(4), .SYNC_PATTERN(4'hA), .PARITY_ODD(1'b0),
    .GAP_BITS(0), .CLKS_PER_BIT(4)
  ) u_small (
    .clk(clk), .rst(rst_c), .din(din_c), .vin(vin_c), .ready(ready_c), .dout(dout_c),
    .dout_valid(dout_valid_c), .frame_start(frame_start_c), .busy(busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_a && vin_a && ready_a) acc_t.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_a(input logic [27:0] w, input bit hold);
    int k;
    din_a = w;
    vin_a = 1'b1;
    k = 0;
    while (!ready_a && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("accept_wait", ready_a, 1);
    @(negedge clk);
    if (!hold) vin_a = 1'b0;
  endtask

  task automatic grab_a(output logic [38:0] line, output logic [38:0] vld,
                        output logic [38:0] fs, output int low);
    low = 0;
    for (int i = 0; i < 39; i++) begin
      line[38-i] = dout_a;
      vld[38-i]  = dout_valid_a;
      fs[38-i]   = frame_start_a;
      if (!ready_a && busy_a) low++;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [38:0] line, vld, fs;
    logic [38:0] exp_vld, exp_fs;
    logic [51:0] line_c, vld_c, exp_c;
    logic [12:0] seq_c;
    int          low, k;

    exp_vld = {37'h1F_FFFF_FFFF, 2'b00};
    exp_fs  = {1'b1, 38'h0};

    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    vin_a = 1'b1; din_a = 28'h0000001;
    vin_b = 1'b0; din_b = '0;
    vin_c = 1'b0; din_c = '0;

    // 1: reset with vin high, then the first frame
    @(negedge clk);
    check("rst_ready", ready_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_dout", {dout_a, dout_valid_a, frame_start_a}, 0);
    @(negedge clk);
    check("rst_ready2", ready_a, 0);
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(negedge clk);
    check("rel_ready", ready_a, 1);
    check("rel_busy", busy_a, 0);
    send_a(28'h0000001, 0);
    grab_a(line, vld, fs, low);
    check("t1_line", line, {8'hA5, 28'h0000001, 1'b1, 2'b00});
    check("t1_valid", vld, exp_vld);
    check("t1_fstart", fs, exp_fs);
    check("t1_low", low, 39);
    check("t1_ready_back", {ready_a, busy_a}, 2'b10);

    // 2: payload of ones ending in zero
    send_a(28'hFFFFFFE, 0);
    grab_a(line, vld, fs, low);
    check("t2_line", line, {8'hA5, 28'hFFFFFFE, 1'b1, 2'b00});
    check("t2_valid", vld, exp_vld);

    // 3: mixed payload, 14 ones
    send_a(28'h94BA8F8, 0);
    grab_a(line, vld, fs, low);
    check("t3_line", line, {8'hA5, 28'h94BA8F8, 1'b0, 2'b00});
    check("t3_fstart", fs, exp_fs);

    // 5: vin held high across two frames, din changed mid-frame
    @(negedge clk);
    acc_t.delete();
    send_a(28'h0000001, 1);
    din_a = 28'hFFFFFFE;
    grab_a(line, vld, fs, low);
    check("t5_line1", line, {8'hA5, 28'h0000001, 1'b1, 2'b00});
    check("t5_low1", low, 39);
    @(negedge clk);
    vin_a = 1'b0;
    grab_a(line, vld, fs, low);
    check("t5_line2", line, {8'hA5, 28'hFFFFFFE, 1'b1, 2'b00});
    check("t5_acc_cnt", acc_t.size(), 2);
    check("t5_spacing", (acc_t.size() >= 2) ? acc_t[1] - acc_t[0] : 0, 40);

    // 6: reset during DATA bit 10
    send_a(28'h94BA8F8, 0);
    for (int i = 0; i < 18; i++) @(negedge clk);
    check("t6_bit10", {dout_a, dout_valid_a, busy_a}, 3'b111);
    rst_a = 1'b0;
    @(negedge clk);
    check("t6_abort", {dout_a, dout_valid_a, busy_a, ready_a}, 4'b0000);
    rst_a = 1'b1;
    @(negedge clk);
    check("t6_ready", {ready_a, busy_a}, 2'b10);
    send_a(28'h0000001, 0);
    grab_a(line, vld, fs, low);
    check("t6_line", line, {8'hA5, 28'h0000001, 1'b1, 2'b00});
    check("t6_valid", vld, exp_vld);

    // 2b: odd parity instance
    din_b = 28'hFFFFFFE;
    vin_b = 1'b1;
    k = 0;
    while (!ready_b && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("odd_wait", ready_b, 1);
    @(negedge clk);
    vin_b = 1'b0;
    for (int i = 0; i < 39; i++) begin
      line[38-i] = dout_b;
      @(negedge clk);
    end
    check("odd_line", line, {8'hA5, 28'hFFFFFFE, 1'b0, 2'b00});

    // 4: four clocks per bit, no gap
    seq_c = 13'b1010_10000001_0;
    for (int i = 0; i < 52; i++) exp_c[51-i] = seq_c[12 - i/4];
    din_c = 8'h81;
    vin_c = 1'b1;
    k = 0;
    while (!ready_c && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("slow_wait", ready_c, 1);
    @(negedge clk);
    vin_c = 1'b0;
    low = 0;
    for (int i = 0; i < 52; i++) begin
      line_c[51-i] = dout_c;
      vld_c[51-i]  = dout_valid_c;
      if (frame_start_c) low += (i == 0) ? 1 : 100;
      if (!ready_c && busy_c) low += 1000;
      @(negedge clk);
    end
    check("slow_line", line_c, exp_c);
    check("slow_valid", vld_c, 52'hF_FFFF_FFFF_FFFF);
    check("slow_fs_low", low, 52001);
    check("slow_idle", {ready_c, busy_c, dout_valid_c}, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
